// File: rtl/fb_fifo_feeder.sv
// rtl/fb_fifo_feeder.sv - SDRAM frame-buffer reader feeding the display FIFO in fixed-size bursts
module fb_fifo_feeder #(
    parameter int unsigned       H_RES     = 320,
    parameter int unsigned       V_RES     = 240,
    parameter int unsigned       BURST_LEN = 64,
    parameter int unsigned       ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] FB_BASE   = '0,
    parameter int unsigned       HIGH_WM   = 3968
) (
    input  logic              clk_sdram,
    input  logic              rst_n,
    input  logic              frame_rst,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic              wr_fifo,
    output logic [15:0]       sdram_data,
    input  logic [11:0]       fifo_wrusedw,
    input  logic              fifo_wrfull,
    output logic              buffer_rst,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned       BCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] BEAT_ONE  = BCNT_W'(1);
    localparam logic [16:0]       PIX_STEP  = 17'(BURST_LEN);
    localparam logic [16:0]       PIX_TOTAL = 17'(H_RES * V_RES);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
    localparam logic [12:0]       WM_LIM    = 13'(HIGH_WM);
    localparam logic [12:0]       BURST13   = 13'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE, FLUSH, WAIT_SPACE, REQ, RECV, DRAIN, DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, sync3_q;
    logic [1:0]          flush_cnt_q, flush_cnt_d;
    logic [BCNT_W-1:0]   beat_q, beat_d;
    logic [16:0]         pix_q, pix_d, pix_inc;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_req_q;
    logic                wr_fifo_q, wr_fifo_d;
    logic [15:0]         sdram_data_q, sdram_data_d;
    logic                buffer_rst_q;
    logic                frame_done_q;
    logic                overflow_q, overflow_d;
    logic                frame_evt;
    logic                space_ok;

    assign frame_evt = sync2_q & ~sync3_q;
    assign space_ok  = ({1'b0, fifo_wrusedw} + BURST13) <= WM_LIM;
    assign pix_inc   = pix_q + PIX_STEP;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        beat_d       = beat_q;
        pix_d        = pix_q;
        rd_addr_d    = rd_addr_q;
        wr_fifo_d    = 1'b0;
        sdram_data_d = sdram_data_q;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE: if (frame_evt) state_d = FLUSH;
            FLUSH: begin
                rd_addr_d  = FB_BASE;
                pix_d      = '0;
                beat_d     = '0;
                overflow_d = 1'b0;
                if (frame_evt)               flush_cnt_d = '0;
                else if (flush_cnt_q == 2'd3) state_d    = WAIT_SPACE;
                else                          flush_cnt_d = flush_cnt_q + 2'd1;
            end
            WAIT_SPACE: begin
                if (frame_evt)     state_d = FLUSH;
                else if (space_ok) state_d = REQ;
            end
            REQ: begin
                // Once acked the burst is owed to us, so a restart must drain it.
                if (rd_ack)         state_d = frame_evt ? DRAIN : RECV;
                else if (frame_evt) state_d = FLUSH;
            end
            RECV: begin
                if (rd_valid) begin
                    wr_fifo_d    = ~fifo_wrfull;
                    sdram_data_d = rd_data;
                    if (fifo_wrfull) overflow_d = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        beat_d    = '0;
                        rd_addr_d = rd_addr_q + ADDR_STEP;
                        pix_d     = pix_inc;
                        if (frame_evt)                  state_d = FLUSH;
                        else if (pix_inc == PIX_TOTAL)  state_d = DONE;
                        else                            state_d = WAIT_SPACE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                        if (frame_evt) state_d = DRAIN;
                    end
                end else if (frame_evt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_valid) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = FLUSH;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            DONE:    state_d = frame_evt ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FLUSH && state_q != FLUSH) flush_cnt_d = '0;
    end

    // Outputs are registered from the next state so buffer_rst, an async clear, never glitches.
    always_ff @(posedge clk_sdram or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            flush_cnt_q  <= '0;
            beat_q       <= '0;
            pix_q        <= '0;
            rd_addr_q    <= FB_BASE;
            rd_req_q     <= 1'b0;
            wr_fifo_q    <= 1'b0;
            sdram_data_q <= '0;
            buffer_rst_q <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= frame_rst;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            flush_cnt_q  <= flush_cnt_d;
            beat_q       <= beat_d;
            pix_q        <= pix_d;
            rd_addr_q    <= rd_addr_d;
            rd_req_q     <= (state_d == REQ);
            wr_fifo_q    <= wr_fifo_d;
            sdram_data_q <= sdram_data_d;
            buffer_rst_q <= (state_d == FLUSH);
            frame_done_q <= (state_d == DONE);
            overflow_q   <= overflow_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign wr_fifo    = wr_fifo_q;
    assign sdram_data = sdram_data_q;
    assign buffer_rst = buffer_rst_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fb_fifo_feeder.sv
// tb/tb_fb_fifo_feeder.sv - directed bench for fb_fifo_feeder with a small SDRAM controller model
module tb_fb_fifo_feeder;

    localparam int H = 64;
    localparam int V = 16;
    localparam int BL = 64;
    localparam int AW = 24;
    localparam int NPIX = H * V;
    localparam int NBURST = NPIX / BL;

    logic          clk = 1'b0;
    logic          rst_n, frame_rst, rd_req, rd_ack, rd_valid, wr_fifo, fifo_wrfull;
    logic          buffer_rst, frame_done, overflow;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data, sdram_data;
    logic [11:0]   fifo_wrusedw;

    always #5 clk = ~clk;

    fb_fifo_feeder #(
        .H_RES(H), .V_RES(V), .BURST_LEN(BL), .ADDR_W(AW), .FB_BASE(24'h0), .HIGH_WM(3968)
    ) dut (
        .clk_sdram(clk), .rst_n(rst_n), .frame_rst(frame_rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_fifo(wr_fifo), .sdram_data(sdram_data),
        .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull),
        .buffer_rst(buffer_rst), .frame_done(frame_done), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit           ctl_en = 1'b0;
    int           ack_dly = 3;
    int           dmode = 0;
    int           wf_burst = -1;
    int           c_st, c_cnt, c_beat, c_bursts, c_cur, gdata;
    int           beat_cyc_q[$];
    logic [15:0]  beat_dat_q[$];
    logic [AW-1:0] addr_q[$];
    int           wr_cyc_q[$];
    logic [15:0]  wr_dat_q[$];
    int           done_cnt;

    typedef struct {
        logic [11:0] usedw;
        logic        exp_req;
    } bp_vec_t;
    bp_vec_t bp[5];

    function automatic logic [15:0] pat(input int b);
        case (b)
            0:       return 16'hF800;
            1:       return 16'h07E0;
            2:       return 16'h001F;
            default: return 16'(b);
        endcase
    endfunction

    function automatic logic [15:0] wd(input int idx);
        if (idx < wr_dat_q.size()) return wr_dat_q[idx];
        return 16'hxxxx;
    endfunction

    function automatic int lat(input int wi, input int bi);
        if (wi < wr_cyc_q.size() && bi < beat_cyc_q.size()) return wr_cyc_q[wi] - beat_cyc_q[bi];
        return -1000;
    endfunction

    // Controller model: acks ack_dly cycles after seeing rd_req, then streams BL back-to-back beats.
    initial begin
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0; fifo_wrfull = 1'b0;
        c_st = 0; c_cnt = 0; c_beat = 0; c_bursts = 0; c_cur = 0; gdata = 0;
        forever begin
            @(posedge clk); #1;
            rd_ack = 1'b0; rd_valid = 1'b0; fifo_wrfull = 1'b0;
            if (!rst_n || !ctl_en) begin
                c_st = 0;
            end else begin
                case (c_st)
                    0: if (rd_req) begin c_cnt = 0; c_st = 1; end
                    1: begin
                        if (!rd_req) c_st = 0;
                        else begin
                            c_cnt++;
                            if (c_cnt >= ack_dly) begin
                                rd_ack = 1'b1;
                                addr_q.push_back(rd_addr);
                                c_cur = c_bursts; c_bursts++;
                                c_beat = 0; c_st = 2;
                            end
                        end
                    end
                    default: begin
                        rd_valid = 1'b1;
                        rd_data = (dmode == 1) ? pat(c_beat) : 16'(gdata);
                        fifo_wrfull = (c_cur == wf_burst) && (c_beat inside {[5:7]});
                        beat_cyc_q.push_back(cyc);
                        beat_dat_q.push_back(rd_data);
                        gdata++; c_beat++;
                        if (c_beat == BL) c_st = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (wr_fifo === 1'b1) begin
                wr_cyc_q.push_back(cyc);
                wr_dat_q.push_back(sdram_data);
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic frame_event(output int hi);
        bit seen;
        hi = 0; seen = 1'b0;
        frame_rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 2) frame_rst = 1'b0;
            if (buffer_rst) begin hi++; seen = 1'b1; end
            else if (seen) return;
        end
        frame_rst = 1'b0;
        hi = -1;
    endtask

    int hi, ok, err;
    int b_w, b_b, b_a, f_w, f_b, f_a, f_d;

    initial begin
        bp[0] = '{12'd4095, 1'b0};
        bp[1] = '{12'd3905, 1'b0};
        bp[2] = '{12'd3904, 1'b1};
        bp[3] = '{12'd3000, 1'b1};
        bp[4] = '{12'd0,    1'b1};

        rst_n = 1'b0; frame_rst = 1'b0; fifo_wrusedw = 12'd0;
        repeat (3) tick();
        check("rst_buffer_rst", 32'(buffer_rst), 1);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_fifo", 32'(wr_fifo), 0);
        check("rst_sdram_data", 32'(sdram_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();
        check("rel_buffer_rst", 32'(buffer_rst), 0);
        repeat (5) tick();
        check("idle_rd_req", 32'(rd_req), 0);

        for (int i = 0; i < 5; i++) begin
            fifo_wrusedw = 12'd4095;
            frame_event(hi);
            check("bp_flush_len", 32'(hi), 4);
            fifo_wrusedw = bp[i].usedw;
            tick();
            check("bp_rd_req", 32'(rd_req), 32'(bp[i].exp_req));
            repeat (3) tick();
            check("bp_rd_req_hold", 32'(rd_req), 32'(bp[i].exp_req));
        end
        fifo_wrusedw = 12'd4095;
        frame_event(hi);
        check("req_abort_flush_len", 32'(hi), 4);
        check("req_abort_rd_req", 32'(rd_req), 0);

        ctl_en = 1'b1; dmode = 1; wf_burst = c_bursts;
        b_w = wr_dat_q.size(); b_b = beat_dat_q.size();
        fifo_wrusedw = 12'd0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (rd_req) begin ok = 1; break; end end
        check("full_req_seen", 32'(ok), 1);
        fifo_wrusedw = 12'd4095;
        for (int i = 0; i < 200; i++) begin tick(); if (beat_dat_q.size() - b_b >= BL) break; end
        repeat (4) tick();
        check("full_beats", 32'(beat_dat_q.size() - b_b), BL);
        check("full_writes", 32'(wr_dat_q.size() - b_w), 61);
        check("full_overflow", 32'(overflow), 1);
        check("lat_data0", 32'(wd(b_w + 0)), 32'h0000F800);
        check("lat_data1", 32'(wd(b_w + 1)), 32'h000007E0);
        check("lat_data2", 32'(wd(b_w + 2)), 32'h0000001F);
        check("lat_cycles0", 32'(lat(b_w + 0, b_b + 0)), 1);
        check("lat_cycles2", 32'(lat(b_w + 2, b_b + 2)), 1);
        check("full_skip_data", 32'(wd(b_w + 5)), 8);
        check("full_next_addr", 32'(rd_addr), BL);
        check("full_rd_req_idle", 32'(rd_req), 0);
        frame_event(hi);
        check("full_flush_len", 32'(hi), 4);
        check("full_ovf_cleared", 32'(overflow), 0);
        check("full_addr_cleared", 32'(rd_addr), 0);

        dmode = 0;
        b_w = wr_dat_q.size(); b_b = beat_dat_q.size(); b_a = addr_q.size();
        fifo_wrusedw = 12'd0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (beat_dat_q.size() - b_b >= 18) begin ok = 1; break; end
        end
        check("mid_beats_seen", 32'(ok), 1);
        frame_event(hi);
        check("mid_flush_len", 32'(hi), 4);
        f_w = wr_dat_q.size(); f_b = beat_dat_q.size(); f_a = addr_q.size(); f_d = done_cnt;
        check("mid_writes", 32'(f_w - b_w), 20);
        check("mid_beats_drained", 32'(f_b - b_b), BL);
        check("mid_one_burst", 32'(f_a - b_a), 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (rd_req) begin ok = 1; break; end end
        check("mid_req_again", 32'(ok), 1);
        check("mid_addr_base", 32'(rd_addr), 0);

        ok = 0;
        for (int i = 0; i < 6000; i++) begin tick(); if (done_cnt != f_d) begin ok = 1; break; end end
        check("frame_done_seen", 32'(ok), 1);
        repeat (10) tick();
        check("frame_done_pulses", 32'(done_cnt - f_d), 1);
        check("frame_writes", 32'(wr_dat_q.size() - f_w), NPIX);
        check("frame_bursts", 32'(addr_q.size() - f_a), NBURST);
        err = 0;
        for (int i = 0; i < NBURST; i++)
            if (f_a + i >= addr_q.size() || addr_q[f_a + i] !== AW'(i * BL)) err++;
        check("frame_addr_seq", 32'(err), 0);
        err = 0;
        for (int i = 0; i < NPIX; i++)
            if (f_b + i >= beat_dat_q.size() || wd(f_w + i) !== beat_dat_q[f_b + i]) err++;
        check("frame_data", 32'(err), 0);
        check("frame_idle_req", 32'(rd_req), 0);
        check("frame_end_addr", 32'(rd_addr), NPIX);
        check("frame_overflow", 32'(overflow), 0);

        frame_event(hi);
        check("arst_flush_len", 32'(hi), 4);
        b_w = wr_dat_q.size();
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (wr_dat_q.size() - b_w >= BL + 10) begin ok = 1; break; end
        end
        check("arst_mid_burst", 32'(ok), 1);
        rst_n = 1'b0;
        #1;
        check("arst_rd_req", 32'(rd_req), 0);
        check("arst_rd_addr", 32'(rd_addr), 0);
        check("arst_wr_fifo", 32'(wr_fifo), 0);
        check("arst_sdram_data", 32'(sdram_data), 0);
        check("arst_buffer_rst", 32'(buffer_rst), 1);
        check("arst_frame_done", 32'(frame_done), 0);
        check("arst_overflow", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_rel_buffer_rst", 32'(buffer_rst), 0);
        repeat (5) tick();
        check("arst_idle_req", 32'(rd_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_fifo_feeder.md
FB_FIFO_FEEDER -- requirements
Module: fb_fifo_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- BURST_LEN, 64, 16-bit words per SDRAM read burst; must divide H_RES*V_RES.
- ADDR_W, 24, SDRAM word-address width.
- FB_BASE, 0, frame buffer start word address.
- HIGH_WM, 3968, maximum FIFO write-side fill after a burst completes.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_sdram, in, 1, the block's only clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_rst, in, 1, display frame-start strobe from the VGA clock domain; asynchronous to clk_sdram.
- rd_req, out, 1, burst read request to the SDRAM controller.
- rd_addr, out, ADDR_W, burst start word address.
- rd_ack, in, 1, controller has accepted the request (1-cycle pulse).
- rd_valid, in, 1, read data beat valid.
- rd_data, in, 16, read data beat (RGB565).
- wr_fifo, out, 1, display FIFO write enable.
- sdram_data, out, 16, display FIFO write data.
- fifo_wrusedw, in, 12, display FIFO write-side fill level.
- fifo_wrfull, in, 1, display FIFO full.
- buffer_rst, out, 1, display FIFO asynchronous clear, active-high.
- frame_done, out, 1, one-cycle pulse when the last burst of a frame has been written.
- overflow, out, 1, sticky flag: a beat was dropped because the FIFO was full.

Function
REQ-003 The block SHALL synchronise frame_rst through a 2-flop synchroniser and act on a rising edge of the synchronised signal (frame event).
REQ-004 The block SHALL implement these states: IDLE, FLUSH, WAIT_SPACE, REQ, RECV, DRAIN, DONE.
REQ-005 IDLE SHALL go to FLUSH on a frame event and otherwise hold.
REQ-006 FLUSH SHALL:
- assert buffer_rst for exactly 4 cycles;
- load rd_addr=FB_BASE and set the pixel count to 0;
- clear overflow;
- then go to WAIT_SPACE.
REQ-007 WAIT_SPACE SHALL go to REQ in the cycle in which fifo_wrusedw + BURST_LEN <= HIGH_WM, computed 13 bits wide.
REQ-008 REQ SHALL hold rd_req=1 with rd_addr stable until rd_ack=1, then go to RECV with rd_req=0 in the next cycle.
REQ-009 RECV SHALL register each rd_valid beat: wr_fifo=1 and sdram_data=rd_data one cycle later (latency 1).
REQ-010 RECV SHALL count beats; after BURST_LEN beats it SHALL:
- add BURST_LEN to rd_addr and to the pixel count (17 bits);
- go to DONE if the count equals H_RES*V_RES, otherwise to WAIT_SPACE.
REQ-011 If fifo_wrfull=1 when a beat would be written, the block SHALL suppress that write, set overflow, and still count the beat.
REQ-012 DONE SHALL pulse frame_done for one cycle and go to IDLE.
REQ-013 A frame event SHALL restart the frame from any state:
- from IDLE, WAIT_SPACE, DONE or FLUSH: go to FLUSH, and restart the 4-cycle pulse if already in FLUSH;
- from REQ before rd_ack: drop rd_req next cycle and go to FLUSH;
- from REQ in the same cycle as rd_ack, or from RECV: go to DRAIN.
REQ-014 DRAIN SHALL accept and discard the remaining beats of the outstanding burst (wr_fifo=0), then go to FLUSH.
REQ-015 rd_valid SHALL be ignored outside RECV and DRAIN.
REQ-016 At most one burst SHALL be outstanding at any time.
REQ-017 rd_addr SHALL wrap modulo 2^ADDR_W.

Reset
REQ-018 While rst_n=0 the block SHALL set: state=IDLE, rd_req=0, rd_addr=FB_BASE, wr_fifo=0, sdram_data=0, buffer_rst=1, frame_done=0, overflow=0, synchroniser flops=0, beat count=0, pixel count=0.
REQ-019 After reset release, buffer_rst SHALL deassert on the first clk_sdram edge, and the block SHALL wait in IDLE for a frame event.

Verification
REQ-020 Full frame: one frame_rst pulse, controller acks after 3 cycles, fifo_wrusedw=0 -> exactly 1200 bursts with addresses 0, 64, ... 76736; 76800 writes; one frame_done pulse.
REQ-021 Back-pressure: fifo_wrusedw=3905 -> stays in WAIT_SPACE with rd_req=0; at 3904 -> rd_req=1 on the next cycle.
REQ-022 Mid-burst restart: frame_rst after beat 20 of a burst -> remaining 44 beats dropped, buffer_rst high for 4 cycles, next rd_addr=FB_BASE.
REQ-023 Full FIFO: fifo_wrfull=1 for beats 5 to 7 -> 61 writes, overflow=1, burst completes normally; overflow=0 after the next FLUSH.
REQ-024 Latency and data: beat values 0xF800, 0x07E0, 0x001F on consecutive cycles -> same values on sdram_data with wr_fifo=1, each one cycle later.
REQ-025 Async reset in RECV: rst_n low mid-burst -> all outputs at reset values immediately, independent of the clock.
